// File: rtl/div.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}; a zero divisor yields 0.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t      state, state_d;
  logic [64:0] dividend, dividend_d;
  logic [31:0] divisor, divisor_d;
  logic [5:0]  cnt, cnt_d;
  logic        neg1, neg1_d;
  logic        neg2, neg2_d;
  logic [63:0] result_d;
  logic        ready_d;

  logic [32:0] trial;
  logic [31:0] abs1, abs2;
  logic [31:0] quot, rem;
  logic        sneg1, sneg2;

  // Operand magnitudes, trial subtraction and sign fix-up of the result
  always_comb begin
    sneg1 = signed_div_i & opdata1_i[31];
    sneg2 = signed_div_i & opdata2_i[31];
    abs1  = sneg1 ? 32'd0 - opdata1_i : opdata1_i;
    abs2  = sneg2 ? 32'd0 - opdata2_i : opdata2_i;
    trial = {1'b0, dividend[63:32]} - {1'b0, divisor};
    quot  = (neg1 ^ neg2) ? 32'd0 - dividend[31:0]
                          : dividend[31:0];
    rem   = neg1 ? 32'd0 - dividend[64:33]
                 : dividend[64:33];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state;
    dividend_d = dividend;
    divisor_d  = divisor;
    cnt_d      = cnt;
    neg1_d     = neg1;
    neg2_d     = neg2;
    result_d   = result_o;
    ready_d    = ready_o;
    unique case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = BYZERO;
          end else begin
            neg1_d     = sneg1;
            neg2_d     = sneg2;
            dividend_d = {32'd0, abs1, 1'b0};
            divisor_d  = abs2;
            cnt_d      = 6'd0;
            state_d    = ON;
          end
        end
      end
      BYZERO: begin
        dividend_d = 65'd0;
        result_d   = 64'd0;
        ready_d    = 1'b1;
        state_d    = END;
      end
      ON: begin
        if (annul_i) begin
          cnt_d   = 6'd0;
          state_d = FREE;
        end else if (cnt != 6'd32) begin
          if (trial[32])
            dividend_d = {dividend[63:0], 1'b0};
          else
            dividend_d = {trial[31:0], dividend[31:0], 1'b1};
          cnt_d = cnt + 6'd1;
        end else begin
          result_d = {rem, quot};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        if (!start_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
          state_d  = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      dividend <= 65'd0;
      divisor  <= 32'd0;
      cnt      <= 6'd0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_d;
      dividend <= dividend_d;
      divisor  <= divisor_d;
      cnt      <= cnt_d;
      neg1     <= neg1_d;
      neg2     <= neg2_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule
